// File: rtl/lcd_ctrl_param_if.sv
// Bundles the host command port and the IROM/IRAM memory ports of lcd_ctrl_param.
// The controller sits on the slave modport; the environment drives commands and ROM data.
interface lcd_ctrl_param_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Image-window processor: loads an IMG_W x IMG_H image from IROM, applies 2x2 window
// commands from the host and streams the buffer to IRAM on request. All outputs registered.
module lcd_ctrl_param #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input logic            clk,
  input logic            reset,
  lcd_ctrl_param_if.slave bus
);
  localparam int unsigned N  = IMG_W * IMG_H;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = AW - CW;
  localparam logic [AW-1:0] P0Init = AW'((IMG_H / 2 - 1) * IMG_W + IMG_W / 2 - 1);
  localparam logic [AW-1:0] Last   = AW'(N - 1);
  localparam logic [AW-1:0] WStep  = AW'(IMG_W);

  typedef enum logic [2:0] {StLoad, StIdle, StExec, StWrite, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] irom_a_q, irom_a_d, iram_a_q, iram_a_d, p0_q, p0_d;
  logic [DW-1:0] iram_d_q, iram_d_d;
  logic          irom_rd_q, irom_rd_d, iram_valid_q, iram_valid_d;
  logic          done_q, done_d, busy_q, busy_d;
  logic [DW-1:0] pix_q [N];
  logic [DW-1:0] pix_d [N];

  logic [AW-1:0] p1, p2, p3;
  logic [DW-1:0] v0, v1, v2, v3, mx01, mx23, mx, mn01, mn23, mn, avg;
  logic [DW+1:0] sum;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  assign p1   = p0_q + AW'(1);
  assign p2   = p0_q + WStep;
  assign p3   = p2 + AW'(1);
  assign v0   = pix_q[p0_q];
  assign v1   = pix_q[p1];
  assign v2   = pix_q[p2];
  assign v3   = pix_q[p3];
  assign mx01 = (v0 > v1) ? v0 : v1;
  assign mx23 = (v2 > v3) ? v2 : v3;
  assign mx   = (mx01 > mx23) ? mx01 : mx23;
  assign mn01 = (v0 < v1) ? v0 : v1;
  assign mn23 = (v2 < v3) ? v2 : v3;
  assign mn   = (mn01 < mn23) ? mn01 : mn23;
  // Two extra bits keep the four-way sum exact before the divide by four.
  assign sum  = {2'b00, v0} + {2'b00, v1} + {2'b00, v2} + {2'b00, v3};
  assign avg  = sum[DW+1:2];
  assign row  = p0_q[AW-1:CW];
  assign col  = p0_q[CW-1:0];

  always_comb begin
    state_d      = state_q;
    irom_a_d     = irom_a_q;
    irom_rd_d    = irom_rd_q;
    iram_a_d     = iram_a_q;
    iram_d_d     = iram_d_q;
    iram_valid_d = iram_valid_q;
    done_d       = done_q;
    busy_d       = busy_q;
    p0_d         = p0_q;
    pix_d        = pix_q;
    case (state_q)
      StLoad: begin
        if (!irom_rd_q) begin
          irom_rd_d = 1'b1;
        end else begin
          pix_d[irom_a_q] = bus.IROM_Q;
          if (irom_a_q == Last) begin
            irom_a_d  = '0;
            irom_rd_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = StIdle;
          end else begin
            irom_a_d = irom_a_q + AW'(1);
          end
        end
      end
      StIdle: begin
        if (bus.cmd_valid) begin
          busy_d  = 1'b1;
          state_d = StExec;
          case (bus.cmd)
            4'd0: begin
              state_d      = StWrite;
              iram_valid_d = 1'b1;
              iram_a_d     = '0;
              iram_d_d     = pix_q[0];
            end
            4'd1: if (row != '0) p0_d = p0_q - WStep;
            4'd2: if (row < RW'(IMG_H - 2)) p0_d = p0_q + WStep;
            4'd3: if (col != '0) p0_d = p0_q - AW'(1);
            4'd4: if (col < CW'(IMG_W - 2)) p0_d = p0_q + AW'(1);
            4'd5: begin
              pix_d[p0_q] = mx; pix_d[p1] = mx; pix_d[p2] = mx; pix_d[p3] = mx;
            end
            4'd6: begin
              pix_d[p0_q] = mn; pix_d[p1] = mn; pix_d[p2] = mn; pix_d[p3] = mn;
            end
            4'd7: begin
              pix_d[p0_q] = avg; pix_d[p1] = avg; pix_d[p2] = avg; pix_d[p3] = avg;
            end
            4'd8: begin
              pix_d[p0_q] = v1; pix_d[p1] = v3; pix_d[p3] = v2; pix_d[p2] = v0;
            end
            4'd9: begin
              pix_d[p0_q] = v2; pix_d[p2] = v3; pix_d[p3] = v1; pix_d[p1] = v0;
            end
            4'd10: begin
              pix_d[p0_q] = v2; pix_d[p2] = v0; pix_d[p1] = v3; pix_d[p3] = v1;
            end
            4'd11: begin
              pix_d[p0_q] = v1; pix_d[p1] = v0; pix_d[p2] = v3; pix_d[p3] = v2;
            end
            4'd12: begin
              state_d   = StLoad;
              irom_a_d  = '0;
              irom_rd_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StExec: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      StWrite: begin
        if (iram_a_q == Last) begin
          state_d      = StDone;
          iram_valid_d = 1'b0;
          iram_a_d     = '0;
          done_d       = 1'b1;
        end else begin
          iram_a_d = iram_a_q + AW'(1);
          iram_d_d = pix_q[iram_a_q + AW'(1)];
        end
      end
      StDone: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StLoad;
      irom_a_q     <= '0;
      irom_rd_q    <= 1'b0;
      iram_a_q     <= '0;
      iram_d_q     <= '0;
      iram_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b1;
      p0_q         <= P0Init;
    end else begin
      state_q      <= state_d;
      irom_a_q     <= irom_a_d;
      irom_rd_q    <= irom_rd_d;
      iram_a_q     <= iram_a_d;
      iram_d_q     <= iram_d_d;
      iram_valid_q <= iram_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      p0_q         <= p0_d;
    end
  end

  // Image buffer needs no reset; it is always reloaded before use.
  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

  assign bus.IROM_rd    = irom_rd_q;
  assign bus.IROM_A     = irom_a_q;
  assign bus.IRAM_valid = iram_valid_q;
  assign bus.IRAM_D     = iram_d_q;
  assign bus.IRAM_A     = iram_a_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: an 8x8/DW=8 instance and a 16x4/DW=10 instance,
// each fed from a combinational ROM array, with write-outs compared to a hand-built image.
module tb_lcd_ctrl_param;
  localparam int unsigned N = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl_param_if #(.DW(8),  .AW(6)) bus_a ();
  lcd_ctrl_param_if #(.DW(10), .AW(6)) bus_b ();

  lcd_ctrl_param #(.DW(8), .IMG_W(8), .IMG_H(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );
  lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [7:0] rom_a [N];
  logic [9:0] rom_b [N];
  assign bus_a.IROM_Q = rom_a[bus_a.IROM_A];
  assign bus_b.IROM_Q = rom_b[bus_b.IROM_A];

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_img [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic f_busy(input int w);
    return (w == 0) ? bus_a.busy : bus_b.busy;
  endfunction
  function automatic logic f_done(input int w);
    return (w == 0) ? bus_a.done : bus_b.done;
  endfunction
  function automatic logic f_valid(input int w);
    return (w == 0) ? bus_a.IRAM_valid : bus_b.IRAM_valid;
  endfunction
  function automatic logic f_rd(input int w);
    return (w == 0) ? bus_a.IROM_rd : bus_b.IROM_rd;
  endfunction
  function automatic logic [5:0] f_iroma(input int w);
    return (w == 0) ? bus_a.IROM_A : bus_b.IROM_A;
  endfunction
  function automatic logic [5:0] f_irama(input int w);
    return (w == 0) ? bus_a.IRAM_A : bus_b.IRAM_A;
  endfunction
  function automatic logic [9:0] f_iramd(input int w);
    return (w == 0) ? {2'b00, bus_a.IRAM_D} : bus_b.IRAM_D;
  endfunction

  task automatic drive(input int w, input logic [3:0] c, input logic v);
    if (w == 0) begin
      bus_a.cmd = c; bus_a.cmd_valid = v;
    end else begin
      bus_b.cmd = c; bus_b.cmd_valid = v;
    end
  endtask

  // Entered just after the edge that put the DUT in LOAD with IROM_rd still low.
  task automatic load_seq(input int w);
    check("load_busy0", f_busy(w), 1);
    check("load_rd0", f_rd(w), 0);
    step();
    check("load_rd1", f_rd(w), 1);
    check("load_a0", f_iroma(w), 0);
    repeat (63) step();
    check("load_a63", f_iroma(w), 63);
    check("load_busy63", f_busy(w), 1);
    step();
    check("load_busy_end", f_busy(w), 0);
    check("load_rd_end", f_rd(w), 0);
    check("load_a_end", f_iroma(w), 0);
    check("load_done", f_done(w), 0);
  endtask

  task automatic do_cmd(input int w, input logic [3:0] c);
    drive(w, c, 1'b1);
    step();
    drive(w, 4'd0, 1'b0);
    check("exec_busy", f_busy(w), 1);
    step();
    check("exec_idle", f_busy(w), 0);
  endtask

  task automatic reload(input int w);
    drive(w, 4'd12, 1'b1);
    step();
    drive(w, 4'd0, 1'b0);
    load_seq(w);
  endtask

  task automatic write_out(input int w, input int inject_k);
    drive(w, 4'd0, 1'b1);
    step();
    drive(w, 4'd0, 1'b0);
    for (int k = 0; k < N; k++) begin
      check("wr_valid_addr", {f_valid(w), f_irama(w)}, {1'b1, 6'(k)});
      check("wr_data", f_iramd(w), exp_img[k]);
      if (k == inject_k) drive(w, 4'd10, 1'b1);
      step();
      if (k == inject_k) drive(w, 4'd0, 1'b0);
    end
    check("wr_end_valid", f_valid(w), 0);
    check("wr_done", f_done(w), 1);
    check("wr_done_busy", f_busy(w), 1);
    step();
    check("wr_done_clear", f_done(w), 0);
    check("wr_busy_clear", f_busy(w), 0);
  endtask

  task automatic init_exp_a();
    for (int k = 0; k < N; k++) exp_img[k] = 10'(k);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rom_a[k] = 8'(k);
      rom_b[k] = 10'(k);
    end
    rom_b[23] = 10'd1023; rom_b[24] = 10'd1023;
    rom_b[39] = 10'd1023; rom_b[40] = 10'd1023;
    drive(0, 4'd0, 1'b0);
    drive(1, 4'd0, 1'b0);

    reset = 1'b0;
    step();
    step();
    check("rst_busy", f_busy(0), 1);
    check("rst_rd", f_rd(0), 0);
    check("rst_valid", f_valid(0), 0);
    check("rst_done", f_done(0), 0);
    check("rst_iroma", f_iroma(0), 0);
    check("rst_irama", f_irama(0), 0);
    check("rst_iramd", f_iramd(0), 0);
    check("rst_busy_b", f_busy(1), 1);
    reset = 1'b1;
    load_seq(0);

    init_exp_a();
    write_out(0, -1);

    // avg of 27,28,35,36 = 126/4 -> 31
    do_cmd(0, 4'd7);
    exp_img[27] = 31; exp_img[28] = 31; exp_img[35] = 31; exp_img[36] = 31;
    write_out(0, -1);

    reload(0);
    init_exp_a();
    do_cmd(0, 4'd5);
    exp_img[27] = 36; exp_img[28] = 36; exp_img[35] = 36; exp_img[36] = 36;
    write_out(0, -1);

    reload(0);
    init_exp_a();
    do_cmd(0, 4'd6);
    exp_img[27] = 27; exp_img[28] = 27; exp_img[35] = 27; exp_img[36] = 27;
    write_out(0, -1);

    // Up x4 clamps at origin 3, right x5 clamps at origin 6, then CW rotate.
    reload(0);
    init_exp_a();
    repeat (4) do_cmd(0, 4'd1);
    repeat (5) do_cmd(0, 4'd4);
    do_cmd(0, 4'd9);
    exp_img[6] = 14; exp_img[7] = 6; exp_img[15] = 7; exp_img[14] = 15;
    write_out(0, -1);

    // cmd_valid held high with "left": only edges 1 and 3 accept -> origin 4.
    drive(0, 4'd3, 1'b1);
    step(); check("b2b_busy1", f_busy(0), 1);
    step(); check("b2b_busy2", f_busy(0), 0);
    step(); check("b2b_busy3", f_busy(0), 1);
    step(); check("b2b_busy4", f_busy(0), 0);
    drive(0, 4'd0, 1'b0);
    do_cmd(0, 4'd11);
    exp_img[4] = 5; exp_img[5] = 4; exp_img[12] = 13; exp_img[13] = 12;
    do_cmd(0, 4'd13);
    write_out(0, 30);
    write_out(0, -1);

    // Reset during a write-out at k=20.
    drive(0, 4'd0, 1'b1);
    step();
    drive(0, 4'd0, 1'b0);
    repeat (20) step();
    check("midwr_addr", {f_valid(0), f_irama(0)}, {1'b1, 6'd20});
    reset = 1'b0;
    step();
    check("midwr_valid", f_valid(0), 0);
    check("midwr_done", f_done(0), 0);
    check("midwr_busy", f_busy(0), 1);
    reset = 1'b1;
    load_seq(0);
    init_exp_a();
    do_cmd(0, 4'd10);
    exp_img[27] = 35; exp_img[35] = 27; exp_img[28] = 36; exp_img[36] = 28;
    write_out(0, -1);

    // Reload keeps the moved window: origin 35, avg(35,36,43,44) = 39.
    do_cmd(0, 4'd2);
    reload(0);
    init_exp_a();
    do_cmd(0, 4'd7);
    exp_img[35] = 39; exp_img[36] = 39; exp_img[43] = 39; exp_img[44] = 39;
    write_out(0, -1);

    // 16x4, DW=10 instance: origin 23, avg of four 1023 stays 1023.
    for (int k = 0; k < N; k++) exp_img[k] = rom_b[k];
    do_cmd(1, 4'd7);
    write_out(1, -1);
    do_cmd(1, 4'd2);
    do_cmd(1, 4'd2);
    do_cmd(1, 4'd6);
    exp_img[39] = 55; exp_img[40] = 55; exp_img[55] = 55; exp_img[56] = 55;
    do_cmd(1, 4'd3);
    do_cmd(1, 4'd8);
    exp_img[38] = 55; exp_img[39] = 55; exp_img[55] = 54; exp_img[54] = 38;
    write_out(1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl_param.md
# lcd_ctrl_param

- Parametrised image-window processor; successor of the fixed 8×8 LCD controller.
- Loads an IMG_W×IMG_H pixel image from the image ROM into an internal buffer and applies host commands to a movable 2×2 window.
- Streams the processed image to the image RAM on request, then returns to accept further commands, so an image can be written out multiple times.
- Sits between the host command port and the IROM/IRAM testbench memories.

## Interface
- DW, 8, pixel width in bits.
- IMG_W, 8, image width in pixels; power of two, ≥2.
- IMG_H, 8, image height in pixels; power of two, ≥2.
- AW (localparam), log2(IMG_W*IMG_H), pixel address width; N = IMG_W*IMG_H.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd  in  4  command code.
- cmd_valid  in  1  command strobe.
- IROM_Q  in  DW  ROM data; combinational function of IROM_A.
- IROM_rd  out  1  ROM read enable.
- IROM_A  out  AW  ROM address.
- IRAM_valid  out  1  RAM write strobe.
- IRAM_D  out  DW  RAM write data.
- IRAM_A  out  AW  RAM write address.
- busy  out  1  high = commands ignored.
- done  out  1  one-cycle pulse at end of each write-out.

## Operation
- States: LOAD, IDLE, EXEC, WRITE, DONE. All outputs registered.
- Reset (reset=0 at an edge):
  - state←LOAD, IROM_A←0, IRAM_A←0, IRAM_D←0.
  - IROM_rd←0, IRAM_valid←0, done←0, busy←1.
  - Window origin P0←(IMG_H/2−1)*IMG_W + IMG_W/2−1, i.e. 27 for 8×8.
  - Reset mid-operation aborts the current operation; buffer contents are don't-care until reloaded.
- Window pixels: P0 = origin, P1 = P0+1, P2 = P0+IMG_W, P3 = P0+IMG_W+1.
- LOAD:
  - IROM_rd=1; buf[IROM_A]←IROM_Q each edge; IROM_A increments.
  - After capturing address N−1: IROM_A←0, IROM_rd←0, go to IDLE.
- IDLE: busy=0. A command is accepted at an edge where cmd_valid=1 and busy=0; cmd_valid while busy=1 is ignored and never queued.
- Commands (all except 0 and 12 commit at the acceptance edge, then EXEC holds busy=1 for one cycle):
  - 0 write: go to WRITE.
  - 1 up: row>0 → P0−=IMG_W, else no change.
  - 2 down: row<IMG_H−2 → P0+=IMG_W, else no change.
  - 3 left: col>0 → P0−=1, else no change.
  - 4 right: col<IMG_W−2 → P0+=1, else no change.
  - 5 max: all four window pixels ← max of the four values.
  - 6 min: all four window pixels ← min of the four values.
  - 7 avg: all four window pixels ← floor(sum/4); sum computed at DW+2 bits, no overflow.
  - 8 CCW rotate: P0←P1, P1←P3, P3←P2, P2←P0.
  - 9 CW rotate: P0←P2, P2←P3, P3←P1, P1←P0.
  - 10 mirror X (swap rows): P0↔P2, P1↔P3.
  - 11 mirror Y (swap columns): P0↔P1, P2↔P3.
  - 12 reload: go to LOAD; window origin is unchanged.
  - 13–15: no-op; EXEC still entered.
  - All pixel operations use values from before the edge (simultaneous swap).
- WRITE:
  - N cycles with IRAM_valid=1, IRAM_A=k, IRAM_D=buf[k], k=0..N−1.
  - Then DONE for one cycle: done=1, IRAM_valid=0, IRAM_A←0; then IDLE.
  - The buffer is not modified by a write-out.

## Timing
- Load: reset released at edge R → IROM_rd=1, IROM_A=0 after R. Address k is captured at edge R+1+k; busy falls after edge R+N.
- Simple command accepted at edge E: busy=1 for cycle E..E+1; busy=0 after E+1. Results are visible at the next write-out.
- Write accepted at edge E: IRAM_valid=1 for exactly N cycles from after E; done=1 in cycle N+1; busy=0 from cycle N+2.
- Reload accepted at edge E: LOAD timing as for reset, starting after E.
- busy is high in LOAD, EXEC, WRITE and DONE.
- Window shifts at edges clamp silently; EXEC timing is identical whether or not the window moves.

## Test plan
- 8×8 ROM loaded with pixel=address; issue cmd 0 → 64 writes with IRAM_D==IRAM_A, then a single done pulse, busy low two cycles after last write.
- Default window holds pixels 27,28,35,36; cmd 7 → all four = 31; cmd 5 on fresh load → all = 36; cmd 6 → all = 27.
- cmd 1 ×4 from reset → origin 3 (fourth clamps); cmd 4 ×5 → origin 6 (clamped at col 6); then cmd 9 → buf[6]=14, buf[7]=6, buf[15]=7, buf[14]=15.
- Back-to-back cmd_valid held high: only every other cycle accepted; a cmd presented during WRITE is ignored; two consecutive writes give identical output streams.
- IMG_W=16, IMG_H=4, DW=10: origin 23; avg of 1023×4 → 1023; cmd 2 clamps at row 2.
- Assert reset mid-WRITE at k=20 → IRAM_valid=0 next cycle, reload from 0, no done pulse; cmd 12 mid-session restores ROM image, window position kept.
